// File: rtl/ps2_kbd_ascii.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_ascii
// Brief    : PS/2 set-2 keyboard receiver with modifier tracking and ASCII
//            output strobe. Optional caps lock via KBD_CAPSLOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
module ps2_kbd_ascii #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_out,
    output logic       p_valid,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       err,
    output logic       shift_st
);
    localparam int                 c_TMR_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

    logic [2:0]         ps2c_q;
    logic [1:0]         ps2d_q;
    logic [3:0]         bitcnt_q;
    logic [7:0]         shreg_q;
    logic               parity_q;
    logic [c_TMR_W-1:0] timer_q;
    logic [7:0]         scan_code_q;
    logic               scan_valid_q;
    logic               err_q;
    state_t             state_q, state_d;
    logic               lshift_q, lshift_d;
    logic               rshift_q, rshift_d;
    logic [7:0]         key_q, key_d;
    logic               pval_q, pval_d;
    logic               w_fall;
    logic               w_bit;
    logic               w_upper;
    logic [9:0]         w_map;

    assign w_fall = ps2c_q[2] & ~ps2c_q[1];
    assign w_bit  = ps2d_q[1];

    // {mapped, is_letter, ascii}; letters are returned lowercase
    function automatic logic [9:0] map_code(input logic [7:0] c);
        logic [9:0] r;
        case (c)
            8'h1C: r = {2'b11, 8'h61}; 8'h32: r = {2'b11, 8'h62};
            8'h21: r = {2'b11, 8'h63}; 8'h23: r = {2'b11, 8'h64};
            8'h24: r = {2'b11, 8'h65}; 8'h2B: r = {2'b11, 8'h66};
            8'h34: r = {2'b11, 8'h67}; 8'h33: r = {2'b11, 8'h68};
            8'h43: r = {2'b11, 8'h69}; 8'h3B: r = {2'b11, 8'h6A};
            8'h42: r = {2'b11, 8'h6B}; 8'h4B: r = {2'b11, 8'h6C};
            8'h3A: r = {2'b11, 8'h6D}; 8'h31: r = {2'b11, 8'h6E};
            8'h44: r = {2'b11, 8'h6F}; 8'h4D: r = {2'b11, 8'h70};
            8'h15: r = {2'b11, 8'h71}; 8'h2D: r = {2'b11, 8'h72};
            8'h1B: r = {2'b11, 8'h73}; 8'h2C: r = {2'b11, 8'h74};
            8'h3C: r = {2'b11, 8'h75}; 8'h2A: r = {2'b11, 8'h76};
            8'h1D: r = {2'b11, 8'h77}; 8'h22: r = {2'b11, 8'h78};
            8'h35: r = {2'b11, 8'h79}; 8'h1A: r = {2'b11, 8'h7A};
            8'h45: r = {2'b10, 8'h30}; 8'h16: r = {2'b10, 8'h31};
            8'h1E: r = {2'b10, 8'h32}; 8'h26: r = {2'b10, 8'h33};
            8'h25: r = {2'b10, 8'h34}; 8'h2E: r = {2'b10, 8'h35};
            8'h36: r = {2'b10, 8'h36}; 8'h3D: r = {2'b10, 8'h37};
            8'h3E: r = {2'b10, 8'h38}; 8'h46: r = {2'b10, 8'h39};
            8'h29: r = {2'b10, 8'h20}; 8'h5A: r = {2'b10, 8'h0A};
            8'h66: r = {2'b10, 8'h08};
            default: r = 10'h000;
        endcase
        return r;
    endfunction

    // Synchronizers idle high so reset release never fakes a falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_q <= 3'b111;
            ps2d_q <= 2'b11;
        end else begin
            ps2c_q <= {ps2c_q[1:0], ps2_clk};
            ps2d_q <= {ps2d_q[0], ps2_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt_q     <= 4'd0;
            shreg_q      <= 8'h00;
            parity_q     <= 1'b0;
            timer_q      <= '0;
            scan_code_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            scan_valid_q <= 1'b0;
            err_q        <= 1'b0;
            if (w_fall) begin
                timer_q <= '0;
                case (bitcnt_q)
                    4'd0: begin
                        if (!w_bit) bitcnt_q <= 4'd1;
                        else        err_q    <= 1'b1;
                    end
                    4'd9: begin
                        parity_q <= w_bit;
                        bitcnt_q <= 4'd10;
                    end
                    4'd10: begin
                        bitcnt_q <= 4'd0;
                        if (w_bit && (^{shreg_q, parity_q})) begin
                            scan_valid_q <= 1'b1;
                            scan_code_q  <= shreg_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: begin
                        shreg_q  <= {w_bit, shreg_q[7:1]};
                        bitcnt_q <= (bitcnt_q > 4'd10) ? 4'd0 : bitcnt_q + 4'd1;
                    end
                endcase
            end else begin
                if (timer_q != c_TMR_MAX) timer_q <= timer_q + c_TMR_W'(1);
                if (bitcnt_q != 4'd0 && timer_q == c_TMR_MAX - c_TMR_W'(1)) begin
                    bitcnt_q <= 4'd0;
                    err_q    <= 1'b1;
                end
            end
        end
    end

`ifdef KBD_CAPSLOCK_EN
    logic caps_q, caps_d;
    assign w_upper = (lshift_q | rshift_q) ^ caps_q;
    always_ff @(posedge clk) begin
        if (reset) caps_q <= 1'b0;
        else       caps_q <= caps_d;
    end
`else
    assign w_upper = lshift_q | rshift_q;
`endif

    assign w_map = map_code(scan_code_q);

    always_comb begin
        state_d  = state_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        key_d    = key_q;
        pval_d   = 1'b0;
`ifdef KBD_CAPSLOCK_EN
        caps_d   = caps_q;
`endif
        if (scan_valid_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code_q == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (scan_code_q == 8'hE0) begin
                        state_d = ST_EXT;
                    end else begin
                        if (scan_code_q == 8'h12) lshift_d = 1'b1;
                        if (scan_code_q == 8'h59) rshift_d = 1'b1;
`ifdef KBD_CAPSLOCK_EN
                        if (scan_code_q == 8'h58) caps_d = ~caps_q;
`endif
                        if (w_map[9]) begin
                            pval_d = 1'b1;
                            key_d  = (w_map[8] && w_upper) ? w_map[7:0] - 8'h20 : w_map[7:0];
                        end
                    end
                end
                ST_BRK: begin
                    if (scan_code_q == 8'h12) lshift_d = 1'b0;
                    if (scan_code_q == 8'h59) rshift_d = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    if (scan_code_q == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        if (scan_code_q == 8'h5A) begin
                            pval_d = 1'b1;
                            key_d  = 8'h0A;
                        end
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            key_q    <= 8'h00;
            pval_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            key_q    <= key_d;
            pval_q   <= pval_d;
        end
    end

    assign key_out    = key_q;
    assign p_valid    = pval_q;
    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign err        = err_q;
    assign shift_st   = lshift_q | rshift_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_ascii.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_ascii
// Brief    : Scoreboard bench for ps2_kbd_ascii (KBD_CAPSLOCK_EN aware).
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_kbd_ascii;
    localparam int TMO  = 1000;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_out;
    logic       p_valid;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       err;
    logic       shift_st;

    ps2_kbd_ascii #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_out(key_out), .p_valid(p_valid), .scan_code(scan_code),
        .scan_valid(scan_valid), .err(err), .shift_st(shift_st)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_scan = -10;
    int err_seen = 0;
    int err_exp = 0;
    logic [7:0] key_q [$];
    logic [7:0] scan_q [$];

    // reference model state: pending prefixes and modifiers
    bit m_brk, m_ext, m_ls, m_rs, m_caps;
    logic [7:0] c_letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] c_digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};
    logic [7:0] c_pool [16] = '{8'h1C, 8'h32, 8'h1A, 8'h45, 8'h46, 8'h12, 8'h59,
        8'hF0, 8'hE0, 8'h5A, 8'h66, 8'h29, 8'h58, 8'h2C, 8'h77, 8'h16};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_make(input logic [7:0] b);
        bit up;
        if (b == 8'h12) m_ls = 1;
        if (b == 8'h59) m_rs = 1;
`ifdef KBD_CAPSLOCK_EN
        if (b == 8'h58) m_caps = ~m_caps;
`endif
        up = (m_ls | m_rs) ^ m_caps;
        for (int i = 0; i < 26; i++)
            if (c_letters[i] == b) key_q.push_back(8'(up ? 8'h41 + i : 8'h61 + i));
        for (int i = 0; i < 10; i++)
            if (c_digits[i] == b) key_q.push_back(8'(8'h30 + i));
        if (b == 8'h29) key_q.push_back(8'h20);
        if (b == 8'h5A) key_q.push_back(8'h0A);
        if (b == 8'h66) key_q.push_back(8'h08);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        scan_q.push_back(b);
        if (m_ext && m_brk) begin
            m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else begin
                if (b == 8'h5A) key_q.push_back(8'h0A);
                m_ext = 0;
            end
        end else if (m_brk) begin
            if (b == 8'h12) m_ls = 0;
            if (b == 8'h59) m_rs = 0;
            m_brk = 0;
        end else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else model_make(b);
    endfunction

    // nbits < 11 sends a truncated frame; the caller accounts for the timeout
    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        if (nbits == 11) begin
            if (bad) err_exp++;
            else     model_byte(b);
        end
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
        ps2_data = 1'b1;
        if (nbits == 11) begin
            repeat (100) @(negedge clk);
            check("shift_st", {31'd0, shift_st}, {31'd0, m_ls | m_rs});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_brk = 0; m_ext = 0; m_ls = 0; m_rs = 0; m_caps = 0;
        @(negedge clk);
        check("reset_outputs", {14'd0, key_out, scan_code, p_valid, scan_valid, err, shift_st}, 32'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_v;
    bit pv_prev = 0, sv_prev = 0, er_prev = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (scan_valid) begin
                if (scan_q.size() == 0) check("unexpected_scan_valid", {24'd0, scan_code}, 32'hFFFF);
                else begin
                    exp_v = scan_q.pop_front();
                    check("scan_code", {24'd0, scan_code}, {24'd0, exp_v});
                end
                last_scan = cyc;
            end
            if (p_valid) begin
                if (key_q.size() == 0) check("unexpected_p_valid", {24'd0, key_out}, 32'hFFFF);
                else begin
                    exp_v = key_q.pop_front();
                    check("key_out", {24'd0, key_out}, {24'd0, exp_v});
                end
                check("p_valid_latency", cyc, last_scan + 1);
            end
            if (err) err_seen++;
            if ((p_valid && pv_prev) || (scan_valid && sv_prev) || (err && er_prev))
                check("strobe_width", 32'd2, 32'd1);
        end
        pv_prev = p_valid; sv_prev = scan_valid; er_prev = err;
    end

    initial begin
        logic [7:0] seq [7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
        logic [7:0] ext [7] = '{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'hE0, 8'h12};
        logic [7:0] cap [6] = '{8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h1C};
        @(negedge clk);
        do_reset();
        send_frame(8'h1C, 0, 11);
        foreach (seq[i]) send_frame(seq[i], 0, 11);
        send_frame(8'h1C, 1, 11);
        send_frame(8'h29, 0, 11);
        send_frame(8'h33, 0, 5);
        repeat (TMO + 100) @(negedge clk);
        err_exp++;
        send_frame(8'h5A, 0, 11);
        foreach (ext[i]) send_frame(ext[i], 0, 11);
        foreach (cap[i]) send_frame(cap[i], 0, 11);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h12, 0, 11);
        send_frame(8'h16, 0, 5);
        do_reset();
        repeat (TMO + 100) @(negedge clk);
        send_frame(8'h16, 0, 11);
        for (int n = 0; n < 18; n++)
            send_frame(c_pool[$urandom_range(0, 15)], ($urandom_range(0, 9) == 0), 11);
        repeat (50) @(negedge clk);
        check("err_count", err_seen, err_exp);
        check("key_queue_drained", key_q.size(), 0);
        check("scan_queue_drained", scan_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
